// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall / taken-branch flush controller with saturating event counters
//   clk, reset_n (sync, active low)
//   in : id_ex_enable/memread/branch/register_rd, if_id_register_rs1/rs2, if_id_rs1/rs2_used, ex_branch_taken
//   out: pc_write, pc_sel_target, if_id_write, if_id_flush, id_ex_bubble (combinational)
//        stall_count, flush_count (registered, saturating)
module hazard_ctrl #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_ex_enable,
  input  logic             id_ex_memread,
  input  logic             id_ex_branch,
  input  logic [4:0]       id_ex_register_rd,
  input  logic [4:0]       if_id_register_rs1,
  input  logic [4:0]       if_id_register_rs2,
  input  logic             if_id_rs1_used,
  input  logic             if_id_rs2_used,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             pc_sel_target,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic lu_hz, br_hz, stall_o, brt, flush_o;
  assign lu_hz = id_ex_enable & id_ex_memread & (id_ex_register_rd != 5'd0) &
                 ((if_id_rs1_used & (if_id_register_rs1 == id_ex_register_rd)) |
                  (if_id_rs2_used & (if_id_register_rs2 == id_ex_register_rd)));
  assign br_hz = id_ex_enable & id_ex_branch & ex_branch_taken;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // cnt holds the remaining extra cycles; the hazard cycle itself is spent in RUN
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == RUN) begin
      if (br_hz) begin
        state_nx = FLUSH_CYCLES > 1 ? FLUSH : RUN;
        cnt_nx   = 4'(FLUSH_CYCLES - 1);
      end else if (lu_hz) begin
        state_nx = LOAD_USE_CYCLES > 1 ? STALL : RUN;
        cnt_nx   = 4'(LOAD_USE_CYCLES - 1);
      end
    end else begin
      cnt_nx   = cnt - 4'd1;
      state_nx = cnt == 4'd1 ? RUN : state;
    end
  end
  always_comb begin
    brt           = state == RUN && br_hz;
    stall_o       = state == STALL || (state == RUN && !br_hz && lu_hz);
    flush_o       = state == FLUSH;
    pc_write      = reset_n & ~stall_o;
    pc_sel_target = reset_n & brt;
    if_id_write   = reset_n & ~stall_o;
    if_id_flush   = ~reset_n | brt | flush_o;
    id_ex_bubble  = ~reset_n | stall_o | brt | flush_o;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      stall_count <= (stall_o && !(&stall_count)) ? stall_count + CNT_W'(1) : stall_count;
      flush_count <= (brt && !(&flush_count)) ? flush_count + CNT_W'(1) : flush_count;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of two hazard_ctrl configurations against a cycle model
module tb_hazard_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  logic en, mr, brn, u1, u2, tk;
  logic [4:0] rd, rs1, rs2;
  logic pw0, ps0, iw0, if0, bb0, pw1, ps1, iw1, if1, bb1;
  logic [15:0] sc0, fc0;
  logic [1:0] sc1, fc1;
  int errors = 0, checks = 0;
  bit started = 0;
  int sl[2], fl[2], sc[2], fc[2];
  int luc[2] = '{1, 3};
  int flc[2] = '{1, 3};
  int mx[2] = '{65535, 3};
  logic [4:0] ctl[2];
  int scv[2], fcv[2];
  always #5 clk = ~clk;
  hazard_ctrl #(.LOAD_USE_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) d0 (
    .clk(clk), .reset_n(reset_n), .id_ex_enable(en), .id_ex_memread(mr), .id_ex_branch(brn),
    .id_ex_register_rd(rd), .if_id_register_rs1(rs1), .if_id_register_rs2(rs2),
    .if_id_rs1_used(u1), .if_id_rs2_used(u2), .ex_branch_taken(tk),
    .pc_write(pw0), .pc_sel_target(ps0), .if_id_write(iw0), .if_id_flush(if0), .id_ex_bubble(bb0),
    .stall_count(sc0), .flush_count(fc0));
  hazard_ctrl #(.LOAD_USE_CYCLES(3), .FLUSH_CYCLES(3), .CNT_W(2)) d1 (
    .clk(clk), .reset_n(reset_n), .id_ex_enable(en), .id_ex_memread(mr), .id_ex_branch(brn),
    .id_ex_register_rd(rd), .if_id_register_rs1(rs1), .if_id_register_rs2(rs2),
    .if_id_rs1_used(u1), .if_id_rs2_used(u2), .ex_branch_taken(tk),
    .pc_write(pw1), .pc_sel_target(ps1), .if_id_write(iw1), .if_id_flush(if1), .id_ex_bubble(bb1),
    .stall_count(sc1), .flush_count(fc1));
  assign ctl[0] = {pw0, ps0, iw0, if0, bb0};
  assign ctl[1] = {pw1, ps1, iw1, if1, bb1};
  assign scv[0] = int'(sc0);
  assign fcv[0] = int'(fc0);
  assign scv[1] = int'(sc1);
  assign fcv[1] = int'(fc1);
  function automatic bit lu();
    return en && mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
  endfunction
  function automatic bit br();
    return en && brn && tk;
  endfunction
  // {pc_write, pc_sel_target, if_id_write, if_id_flush, id_ex_bubble}
  function automatic logic [4:0] exp_ctl(int i);
    if (!reset_n) return 5'b00011;
    if (sl[i] > 0 || (fl[i] == 0 && !br() && lu())) return 5'b00001;
    if (fl[i] > 0) return 5'b10111;
    if (br()) return 5'b11111;
    return 5'b10100;
  endfunction
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        sl[i] = 0; fl[i] = 0; sc[i] = 0; fc[i] = 0;
      end else if (sl[i] > 0) begin
        sl[i]--; sc[i]++;
      end else if (fl[i] > 0) begin
        fl[i]--;
      end else if (br()) begin
        fc[i]++; fl[i] = flc[i] - 1;
      end else if (lu()) begin
        sc[i]++; sl[i] = luc[i] - 1;
      end
    end
  end
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ctl%0d", i), int'(ctl[i]), int'(exp_ctl(i)));
        chk($sformatf("stall_count%0d", i), scv[i], sc[i] > mx[i] ? mx[i] : sc[i]);
        chk($sformatf("flush_count%0d", i), fcv[i], fc[i] > mx[i] ? mx[i] : fc[i]);
      end
    end
  end
  task automatic idle();
    en = 0; mr = 0; brn = 0; tk = 0; u1 = 0; u2 = 0; rd = 0; rs1 = 0; rs2 = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 0;
    idle();
    step();
    step();
    reset_n = 1;
  endtask
  task automatic load_use(input logic [4:0] r, input bit use2);
    en = 1; mr = 1; rd = r;
    if (use2) begin rs2 = r; u2 = 1; end else begin rs1 = r; u1 = 1; end
  endtask
  initial begin
    idle();
    step();
    started = 1;
    step();
    @(negedge clk);
    chk("rst_pc_write", pw0, 0);
    chk("rst_if_id_flush", if0, 1);
    chk("rst_bubble", bb0, 1);
    chk("rst_stall_count", sc0, 0);
    chk("rst_flush_count", fc1, 0);
    reset_n = 1;
    @(negedge clk);
    chk("run_pc_write", pw0, 1);
    chk("run_if_id_write", iw0, 1);
    chk("run_bubble", bb0, 0);
    step();
    do_reset();
    load_use(5'd5, 0);
    @(negedge clk);
    chk("lu1_pc_write", pw0, 0);
    chk("lu1_bubble", bb0, 1);
    step();
    idle();
    @(negedge clk);
    chk("lu1_resume", pw0, 1);
    chk("lu1_stall_count", sc0, 1);
    do_reset();
    load_use(5'd7, 1);
    @(negedge clk);
    chk("lu3_c1", pw1, 0);
    step();
    idle();
    @(negedge clk);
    chk("lu3_c2", pw1, 0);
    step();
    @(negedge clk);
    chk("lu3_c3", iw1, 0);
    step();
    @(negedge clk);
    chk("lu3_resume", pw1, 1);
    chk("lu3_stall_count", sc1, 3);
    chk("model_sc1", sc[1], 3);
    do_reset();
    load_use(5'd5, 0);
    brn = 1; tk = 1;
    @(negedge clk);
    chk("br_pc_sel", ps0, 1);
    chk("br_if_id_flush", if0, 1);
    chk("br_pc_write", pw0, 1);
    step();
    idle();
    @(negedge clk);
    chk("br_flush_count", fc0, 1);
    chk("br_stall_count", sc0, 0);
    chk("flush_state_sel", ps1, 0);
    chk("flush_state_iff", if1, 1);
    do_reset();
    en = 1; mr = 1; rd = 0; rs1 = 0; u1 = 1;
    @(negedge clk);
    chk("rd0_no_stall", pw0, 1);
    step();
    rd = 5; rs1 = 5; u1 = 0; rs2 = 6; u2 = 1;
    @(negedge clk);
    chk("unused_no_stall", pw1, 1);
    step();
    rs1 = 5; u1 = 1; en = 0;
    @(negedge clk);
    chk("disabled_no_stall", pw0, 1);
    step();
    idle();
    @(negedge clk);
    chk("no_stall_count", sc1, 0);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      load_use(5'd9, k[0]);
      step();
      idle();
      step();
      step();
    end
    @(negedge clk);
    chk("sat_stall_count", sc1, 3);
    chk("five_stall_count", sc0, 5);
    chk("model_sc1_raw", sc[1], 15);
    step();
    en = 1; brn = 1; tk = 1;
    step();
    idle();
    @(negedge clk);
    chk("mid_flush", if1, 1);
    reset_n = 0;
    step();
    @(negedge clk);
    chk("abort_stall_count", sc1, 0);
    chk("abort_flush_count", fc1, 0);
    chk("abort_pc_write", pw1, 0);
    reset_n = 1;
    @(negedge clk);
    chk("abort_run_flush", if1, 0);
    chk("abort_run_pc_write", pw1, 1);
    step();
    for (int k = 0; k < 4000; k++) begin
      reset_n = ($urandom % 64) != 0;
      en = ($urandom % 4) != 0;
      mr = $urandom % 2;
      brn = ($urandom % 3) == 0;
      tk = $urandom % 2;
      rd = 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      u1 = $urandom % 2;
      u2 = $urandom % 2;
      step();
    end
    @(negedge clk);
    started = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
